// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bundle between the fetch controller and the SRAM-like port.
interface inst_fetch_if #(
    parameter int unsigned WIDTH = 32
);
    logic             inst_req;
    logic [WIDTH-1:0] inst_addr;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [WIDTH-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: one outstanding instruction read, flush-safe, stalls the PC until ready.
// Optional FETCH_ADDR_CHECK_EN: misaligned PC raises excF_adel_o instead of issuing a request.
module inst_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pc_i,
    input  logic              ce_i,
    input  logic              stallD_i,
    input  logic              flushF_i,
    inst_fetch_if.master      mem,
    output logic [WIDTH-1:0]  instF_o,
    output logic [WIDTH-1:0]  pcF_out_o,
    output logic              inst_validF_o,
`ifdef FETCH_ADDR_CHECK_EN
    output logic              excF_adel_o,
`endif
    output logic              fetch_stall_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StValid} state_e;

    state_e           state_q, state_d;
    logic             discard_q, discard_d;
    logic [WIDTH-1:0] inst_addr_q, inst_addr_d;
    logic [WIDTH-1:0] pcF_q, pcF_d;
    logic [WIDTH-1:0] instF_q, instF_d;
`ifdef FETCH_ADDR_CHECK_EN
    logic             excF_q, excF_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            discard_q   <= 1'b0;
            inst_addr_q <= RESET_PC;
            pcF_q       <= RESET_PC;
            instF_q     <= '0;
`ifdef FETCH_ADDR_CHECK_EN
            excF_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            inst_addr_q <= inst_addr_d;
            pcF_q       <= pcF_d;
            instF_q     <= instF_d;
`ifdef FETCH_ADDR_CHECK_EN
            excF_q      <= excF_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        inst_addr_d = inst_addr_q;
        pcF_d       = pcF_q;
        instF_d     = instF_q;
`ifdef FETCH_ADDR_CHECK_EN
        excF_d      = excF_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (ce_i && !flushF_i) begin
                    pcF_d = pc_i;
`ifdef FETCH_ADDR_CHECK_EN
                    if (pc_i[1:0] != 2'b00) begin
                        // Misaligned: deliver a NOP carrying the address-error flag.
                        instF_d = '0;
                        excF_d  = 1'b1;
                        state_d = StValid;
                    end else begin
                        inst_addr_d = pc_i;
                        state_d     = StReq;
                    end
`else
                    inst_addr_d = {pc_i[WIDTH-1:2], 2'b00};
                    state_d     = StReq;
`endif
                end
            end
            StReq: begin
                if (mem.inst_addr_ok) begin
                    discard_d = flushF_i;
                    state_d   = StWait;
                end else if (flushF_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (mem.inst_data_ok) begin
                    if (discard_q || flushF_i) begin
                        discard_d = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        instF_d = mem.inst_rdata;
                        state_d = StValid;
                    end
                end else if (flushF_i) begin
                    // Response still owed by memory; remember to drop it.
                    discard_d = 1'b1;
                end
            end
            StValid: begin
                if (!stallD_i || flushF_i) begin
                    state_d = StIdle;
`ifdef FETCH_ADDR_CHECK_EN
                    excF_d  = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem.inst_req   = (state_q == StReq);
    assign mem.inst_addr  = inst_addr_q;
    assign instF_o        = instF_q;
    assign pcF_out_o      = pcF_q;
    assign inst_validF_o  = (state_q == StValid);
    assign fetch_stall_o  = (state_q != StValid);
`ifdef FETCH_ADDR_CHECK_EN
    assign excF_adel_o    = excF_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: reset, zero-wait fetch, decode stall, flushes, misalignment.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ce, stallD, flushF;
    logic [31:0] instF, pcF_out;
    logic        inst_validF, fetch_stall;
`ifdef FETCH_ADDR_CHECK_EN
    logic        excF_adel;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    inst_fetch_if #(.WIDTH(32)) bus ();

    inst_fetch_ctrl #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc),
        .ce_i          (ce),
        .stallD_i      (stallD),
        .flushF_i      (flushF),
        .mem           (bus.master),
        .instF_o       (instF),
        .pcF_out_o     (pcF_out),
        .inst_validF_o (inst_validF),
`ifdef FETCH_ADDR_CHECK_EN
        .excF_adel_o   (excF_adel),
`endif
        .fetch_stall_o (fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; pc = RST_PC; stallD = 1'b0; flushF = 1'b0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        #1;
        repeat (3) step();
        chk("rst_req", {31'd0, bus.inst_req}, 32'd0);
        chk("rst_addr", bus.inst_addr, RST_PC);
        chk("rst_pcF", pcF_out, RST_PC);
        chk("rst_instF", instF, 32'd0);
        chk("rst_valid", {31'd0, inst_validF}, 32'd0);
        chk("rst_stall", {31'd0, fetch_stall}, 32'd1);

        // Release reset with ce high: request one cycle later.
        rst = 1'b0; ce = 1'b1;
        step();
        chk("req_after_rst", {31'd0, bus.inst_req}, 32'd1);
        chk("addr_after_rst", bus.inst_addr, RST_PC);

        // Zero-wait fetch with decode stalled on arrival.
        bus.inst_addr_ok = 1'b1;
        step();
        chk("wait_req", {31'd0, bus.inst_req}, 32'd0);
        chk("wait_stall", {31'd0, fetch_stall}, 32'd1);
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h24080001;
        stallD = 1'b1;
        step();
        chk("zw_valid", {31'd0, inst_validF}, 32'd1);
        chk("zw_instF", instF, 32'h24080001);
        chk("zw_stall", {31'd0, fetch_stall}, 32'd0);
        chk("zw_pcF", pcF_out, RST_PC);

        // Stray data_ok while VALID must not disturb instF.
        bus.inst_rdata = 32'h99999999; pc = 32'hbfc00004;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_instF", instF, 32'h24080001);
            chk("hold_pcF", pcF_out, RST_PC);
            chk("hold_req", {31'd0, bus.inst_req}, 32'd0);
            chk("hold_stall", {31'd0, fetch_stall}, 32'd0);
        end
        bus.inst_data_ok = 1'b0; stallD = 1'b0;
        step();
        chk("leave_valid", {31'd0, inst_validF}, 32'd0);
        chk("idle_stall", {31'd0, fetch_stall}, 32'd1);
        step();
        chk("next_req", {31'd0, bus.inst_req}, 32'd1);
        chk("next_addr", bus.inst_addr, 32'hbfc00004);
        chk("next_pcF", pcF_out, 32'hbfc00004);

        // Flush while waiting; late data must be dropped.
        bus.inst_addr_ok = 1'b1;
        step();
        bus.inst_addr_ok = 1'b0; flushF = 1'b1; pc = 32'hbfc00380;
        step();
        chk("flw_req", {31'd0, bus.inst_req}, 32'd0);
        chk("flw_valid", {31'd0, inst_validF}, 32'd0);
        flushF = 1'b0;
        step();
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdeadbeef;
        step();
        chk("flw_drop_valid", {31'd0, inst_validF}, 32'd0);
        chk("flw_drop_instF", instF, 32'h24080001);
        bus.inst_data_ok = 1'b0;
        step();
        chk("redir_req", {31'd0, bus.inst_req}, 32'd1);
        chk("redir_addr", bus.inst_addr, 32'hbfc00380);

        // Flush in REQ without addr_ok withdraws the request.
        flushF = 1'b1;
        step();
        chk("flr_req", {31'd0, bus.inst_req}, 32'd0);
        flushF = 1'b0; pc = 32'hbfc00400;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h11111111;
        step();
        chk("flr_instF", instF, 32'h24080001);
        chk("flr_valid", {31'd0, inst_validF}, 32'd0);
        chk("flr_req2", {31'd0, bus.inst_req}, 32'd1);
        chk("flr_addr2", bus.inst_addr, 32'hbfc00400);
        bus.inst_data_ok = 1'b0;

        // Complete it, then hold ce low: no fetch issued.
        bus.inst_addr_ok = 1'b1;
        step();
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3c1d0000;
        step();
        chk("f2_instF", instF, 32'h3c1d0000);
        chk("f2_pcF", pcF_out, 32'hbfc00400);
        bus.inst_data_ok = 1'b0; ce = 1'b0;
        step();
        step();
        chk("ce0_req", {31'd0, bus.inst_req}, 32'd0);
        chk("ce0_stall", {31'd0, fetch_stall}, 32'd1);

        // Misaligned PC.
        ce = 1'b1; pc = 32'hbfc00002;
        step();
`ifdef FETCH_ADDR_CHECK_EN
        chk("mis_req", {31'd0, bus.inst_req}, 32'd0);
        chk("mis_valid", {31'd0, inst_validF}, 32'd1);
        chk("mis_instF", instF, 32'd0);
        chk("mis_exc", {31'd0, excF_adel}, 32'd1);
        chk("mis_pcF", pcF_out, 32'hbfc00002);
        ce = 1'b0;
        step();
        chk("mis_exc_clr", {31'd0, excF_adel}, 32'd0);
`else
        chk("mis_req", {31'd0, bus.inst_req}, 32'd1);
        chk("mis_addr", bus.inst_addr, 32'hbfc00000);
        chk("mis_pcF", pcF_out, 32'hbfc00002);
        ce = 1'b0;
        bus.inst_addr_ok = 1'b1;
        step();
        bus.inst_addr_ok = 1'b0;
`endif

        // Reset mid-transaction (or from IDLE when the misaligned path skipped memory).
        ce = 1'b1; pc = 32'h00000040;
        step();
        bus.inst_addr_ok = 1'b1;
        step();
        bus.inst_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, bus.inst_req}, 32'd0);
        chk("arst_addr", bus.inst_addr, RST_PC);
        chk("arst_pcF", pcF_out, RST_PC);
        chk("arst_instF", instF, 32'd0);
        ce = 1'b0;
        step();
        rst = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h55555555;
        step();
        chk("late_instF", instF, 32'd0);
        chk("late_valid", {31'd0, inst_validF}, 32'd0);
        bus.inst_data_ok = 1'b0;

        // PC at the top of the address space passes through unchanged.
        ce = 1'b1; pc = 32'hfffffffc;
        step();
        chk("wrap_req", {31'd0, bus.inst_req}, 32'd1);
        chk("wrap_addr", bus.inst_addr, 32'hfffffffc);
        ce = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch-stage controller between the PC register and the instruction-memory SRAM-like port.
- Takes the current PC, issues one read request per PC value, and waits for the address and data handshakes.
- Delivers the instruction with a valid flag and asserts a fetch stall back to the PC register until the instruction is ready.
- Handles flushes by discarding in-flight responses.

Parameters:
WIDTH, 32, address/data width
RESET_PC, 32'hbfc00000, reset value of inst_addr and pcF_out

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
pc  input  WIDTH  current PC from the PC register
ce  input  1  PC-register enable; no fetch issued while 0
stallD  input  1  decode not ready; hold delivered instruction
flushF  input  1  cancel current fetch (branch/exception redirect)
inst_req  output  1  request strobe to instruction memory
inst_addr  output  WIDTH  request address (registered)
inst_addr_ok  input  1  memory accepted address this cycle
inst_data_ok  input  1  read data valid this cycle
inst_rdata  input  WIDTH  read data
instF  output  WIDTH  fetched instruction (registered)
pcF_out  output  WIDTH  PC of instF
inst_validF  output  1  instF valid for decode
fetch_stall  output  1  hold PC register (ORed into stallF externally)

Behaviour:
Reset and protocol:
- Reset is asynchronous and active-high on rst; clock is clk.
- On reset: state=IDLE, inst_req=0, inst_addr=RESET_PC, pcF_out=RESET_PC, instF=0, discard=0.
- At most one outstanding request at any time.

States: IDLE, REQ, WAIT, VALID.
- Combinational outputs: inst_req=(state==REQ); inst_validF=(state==VALID); fetch_stall=(state!=VALID).
- Consequence: fetch_stall=1 during reset and whenever ce=0.

IDLE:
- If ce=1 and flushF=0: latch pc into inst_addr and pcF_out, then go to REQ.
- Otherwise stay in IDLE.

REQ:
- inst_addr_ok=1 and flushF=0: go to WAIT.
- inst_addr_ok=1 and flushF=1: go to WAIT with discard=1.
- inst_addr_ok=0 and flushF=1: withdraw the request and go to IDLE.

WAIT:
- inst_data_ok=1 and discard=0 and flushF=0: instF<=inst_rdata, go to VALID.
- inst_data_ok=1 and (discard=1 or flushF=1): drop the data, clear discard, go to IDLE.
- inst_data_ok=0 and flushF=1: set discard=1, stay in WAIT.

VALID:
- instF and pcF_out are held stable.
- stallD=0 or flushF=1: go to IDLE. The PC register advances on this same edge because fetch_stall=0.
- stallD=1 and flushF=0: stay in VALID.

Timing and boundary rules:
- Minimum latency from IDLE to VALID with zero-wait memory: 3 cycles (IDLE, REQ, WAIT).
- inst_data_ok outside WAIT is ignored; instF does not change.
- inst_addr is stable while inst_req=1.
- Reset asserted mid-transaction returns to IDLE immediately. The memory response that arrives after rst deasserts is ignored, because state is not WAIT.
- pc wrap-around (32'hfffffffc to 0) needs no special handling; addresses pass through unchanged.

Optional Feature:
Macro: FETCH_ADDR_CHECK_EN. Adds output excF_adel (1 bit, reset 0).
- When defined: in IDLE, if pc[1:0]!=0, no request is issued. The controller goes directly to VALID with instF=0 (NOP), pcF_out=pc and excF_adel=1. excF_adel clears when VALID is left.
- When not defined: no excF_adel port. inst_addr[1:0] is forced to 2'b00; pcF_out keeps the full pc.

Test Plan:
- Reset release: rst high for 3 cycles, then low with ce=1 and pc=32'hbfc00000 -> inst_req=1 one cycle after ce rises, inst_addr=32'hbfc00000.
- Zero-wait fetch: addr_ok in the REQ cycle, data_ok next cycle with rdata=32'h24080001 -> inst_validF=1 with instF=32'h24080001 and fetch_stall=0 in the following cycle.
- Decode stall: VALID with stallD=1 for 4 cycles -> instF and pcF_out unchanged, fetch_stall=0, no new inst_req. After stallD=0 -> IDLE, then REQ with the new pc (e.g. 32'hbfc00004).
- Flush in WAIT: flushF pulse while waiting; data_ok 2 cycles later with rdata=32'hdeadbeef -> inst_validF stays 0 and the next request uses the redirected pc=32'hbfc00380.
- Flush in REQ without addr_ok: flushF=1, addr_ok=0 -> inst_req drops next cycle, state returns to IDLE, no data accepted.
- FETCH_ADDR_CHECK_EN: pc=32'hbfc00002 -> no inst_req, inst_validF=1, instF=0, excF_adel=1. Without the macro, same pc -> inst_addr=32'hbfc00000.
